// File: rtl/rsa_modexp_sequencer.sv
// rsa_modexp_sequencer: left-to-right binary square-and-multiply sequencer.
// Computes base^exponent mod modulus by driving one shared external modular
// multiplier through a req/ack handshake; holds the multiplier for the whole run.
module rsa_modexp_sequencer #(
    parameter int unsigned WIDTH     = 128,
    parameter int unsigned EXP_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [WIDTH-1:0]     result,
    output logic                 mul_req,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    output logic [WIDTH-1:0]     mul_n,
    input  logic                 mul_ack,
    input  logic [WIDTH-1:0]     mul_result
);

    localparam int unsigned    IdxW   = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [IdxW-1:0] IdxTop = IdxW'(EXP_WIDTH - 1);
    localparam logic [IdxW-1:0] IdxOne = IdxW'(1);

    typedef enum logic [3:0] {
        StIdle,
        StCheck,
        StScan,
        StSq,
        StSqWait,
        StMul,
        StMulWait,
        StFinish,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       base_q, base_d;
    logic [EXP_WIDTH-1:0]   exp_q, exp_d;
    logic [WIDTH-1:0]       mod_q, mod_d;
    logic [WIDTH-1:0]       acc_q, acc_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   err_q, err_d;
    logic                   mul_req_q, mul_req_d;
    logic [WIDTH-1:0]       mul_a_q, mul_a_d;
    logic [WIDTH-1:0]       mul_b_q, mul_b_d;

    logic exp_bit;
    logic ack_ok;

    assign exp_bit = exp_q[idx_q];
    // Acks are only meaningful while our own request is outstanding.
    assign ack_ok  = mul_ack & mul_req_q;

    // State and datapath registers; reset aborts any operation immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            base_q    <= '0;
            exp_q     <= '0;
            mod_q     <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
            mul_req_q <= 1'b0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            exp_q     <= exp_d;
            mod_q     <= mod_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            result_q  <= result_d;
            err_q     <= err_d;
            mul_req_q <= mul_req_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
        end
    end

    // Next-state logic: exponent scan plus square/multiply request sequencing.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        exp_d     = exp_q;
        mod_d     = mod_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        result_d  = result_q;
        err_d     = err_q;
        mul_req_d = mul_req_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d  = base;
                    exp_d   = exponent;
                    mod_d   = modulus;
                    err_d   = 1'b0;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if ((mod_q == '0) || (base_q >= mod_q)) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = StDone;
                end else if (exp_q == '0) begin
                    result_d = (mod_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                    state_d  = StDone;
                end else begin
                    idx_d   = IdxTop;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (exp_bit) begin
                    acc_d = base_q;
                    if (idx_q == '0) begin
                        state_d = StFinish;
                    end else begin
                        idx_d   = idx_q - IdxOne;
                        state_d = StSq;
                    end
                end else if (idx_q == '0) begin
                    // Unreachable for a nonzero exponent; keeps idx from wrapping.
                    state_d = StFinish;
                end else begin
                    idx_d = idx_q - IdxOne;
                end
            end
            StSq: begin
                mul_a_d   = acc_q;
                mul_b_d   = acc_q;
                mul_req_d = 1'b1;
                state_d   = StSqWait;
            end
            StSqWait: begin
                if (ack_ok) begin
                    acc_d     = mul_result;
                    mul_req_d = 1'b0;
                    if (exp_bit) begin
                        state_d = StMul;
                    end else if (idx_q == '0) begin
                        state_d = StFinish;
                    end else begin
                        idx_d   = idx_q - IdxOne;
                        state_d = StSq;
                    end
                end
            end
            StMul: begin
                mul_a_d   = acc_q;
                mul_b_d   = base_q;
                mul_req_d = 1'b1;
                state_d   = StMulWait;
            end
            StMulWait: begin
                if (ack_ok) begin
                    acc_d     = mul_result;
                    mul_req_d = 1'b0;
                    if (idx_q == '0) begin
                        state_d = StFinish;
                    end else begin
                        idx_d   = idx_q - IdxOne;
                        state_d = StSq;
                    end
                end
            end
            StFinish: begin
                result_d = acc_q;
                state_d  = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy    = (state_q != StIdle) && (state_q != StDone);
    assign done    = (state_q == StDone);
    assign err     = err_q;
    assign result  = result_q;
    assign mul_req = mul_req_q;
    assign mul_a   = mul_a_q;
    assign mul_b   = mul_b_q;
    assign mul_n   = mod_q;

endmodule

// File: doc/rsa_modexp_sequencer.md
Name: rsa_modexp_sequencer

Overview:
- Sequences RSA modular exponentiation, result = base^exponent mod modulus, using left-to-right binary square-and-multiply.
- Does not contain the multiplier. It drives one shared external modular multiplier (modmul) through a req/ack handshake and owns the multiplier for the whole operation.
- Sits between the RSA_BOX register file (which supplies n, e and the message word) and the modmul datapath.
- Reports completion to the register file via done/busy and returns the result word.

Parameters:
WIDTH, 128, width of base, modulus, result and the multiplier operands
EXP_WIDTH, 32, width of the exponent

Ports:
clk  in  1  system clock; the only clock
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  one-cycle request to begin; sampled only in IDLE
base  in  WIDTH  message/ciphertext; latched on accepted start
exponent  in  EXP_WIDTH  e or d; latched on accepted start
modulus  in  WIDTH  n; latched on accepted start
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse when result is valid
err  out  1  set with done when the operation was rejected; held until next accepted start
result  out  WIDTH  final value; held until next accepted start
mul_req  out  1  multiply request to modmul
mul_a  out  WIDTH  operand A
mul_b  out  WIDTH  operand B
mul_n  out  WIDTH  modulus to modmul, equal to the latched modulus
mul_ack  in  1  one-cycle pulse; mul_result valid in the same cycle
mul_result  in  WIDTH  (mul_a*mul_b) mod mul_n

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. busy, done, err, mul_req = 0. result, mul_a, mul_b, mul_n, acc and the bit index are cleared to 0.
- Reset asserted mid-operation aborts immediately. No done is issued. A pending mul_ack arriving after reset releases is ignored.
- IDLE:
  - start=1: latch base/exponent/modulus, clear err, go to CHECK.
  - start while not IDLE: ignored, with no effect on the running operation.
- CHECK (1 cycle):
  - modulus==0 or base>=modulus: err=1, result=0, go to DONE.
  - else exponent==0: result = (modulus==1) ? 0 : 1, go to DONE.
  - else idx=EXP_WIDTH-1, go to SCAN.
- SCAN: one cycle per exponent bit, MSB downward.
  - Exponent bit idx==0: decrement idx.
  - Exponent bit idx==1 (leading one): acc=base.
    - If idx==0, go to FINISH.
    - Otherwise decrement idx and go to SQ.
- SQ: mul_a=mul_b=acc, mul_req=1, go to SQ_WAIT.
- SQ_WAIT: hold mul_req and the operands stable until mul_ack. On ack: acc=mul_result, mul_req=0 the next cycle.
  - Exponent bit idx==1: go to MUL.
  - Else if idx==0: go to FINISH.
  - Else decrement idx, go to SQ.
- MUL: mul_a=acc, mul_b=base, mul_req=1, go to MUL_WAIT.
- MUL_WAIT: on ack, acc=mul_result.
  - If idx==0: go to FINISH.
  - Else decrement idx, go to SQ.
- FINISH: result=acc, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, go to IDLE.
- Handshake rules:
  - mul_req is never re-asserted in the cycle of an ack. There is at least one idle cycle between requests.
  - mul_ack while mul_req=0 is ignored.
  - modmul latency is unbounded; there is no timeout.
- Multiplication count for exponent e with msb position m: m squarings + (popcount(e)-1) multiplies.
- All registers are WIDTH bits with no truncation. idx is ceil(log2(EXP_WIDTH)) bits and never wraps below 0.

Test Plan:
- base=4, exponent=13, modulus=497, modmul model with 3-cycle ack latency -> result=445, err=0, exactly 5 mul_req pulses (operand sequence 4·4, 16·4, 64·64, 120·120, 484·4), one done pulse.
- exponent=0x10001, base=2, modulus=1000003 -> result=2^65537 mod 1000003 (per the golden model), 17 mul_req pulses (16 SQ, 1 MUL).
- Edge inputs:
  - exponent=0, modulus=497 -> result=1 with no mul_req.
  - exponent=0, modulus=1 -> result=0.
  - exponent=1, base=7 -> result=7 with no mul_req.
- Rejected inputs:
  - modulus=0 -> err=1, result=0, done after 2 cycles, no mul_req.
  - base=500, modulus=497 -> err=1.
- Mid-operation events:
  - start pulsed again during SQ_WAIT -> ignored, result unchanged (445 case).
  - reset asserted during MUL_WAIT -> all outputs 0 asynchronously, then a fresh start completes correctly.
- Handshake:
  - mul_ack driven with mul_req=0 -> ignored.
  - Randomized ack latency 1..20 cycles -> mul_a/mul_b stable while mul_req=1, and the result matches the golden model for 100 random 64-bit cases.
